// File: rtl/hex_debug_console.sv
// hex_debug_console
//   Board-level CPU debug front end. Produces the CPU clock from a debounced
//   step key or a divided free-running clock, and shows a hex view of one of
//   several debug words on active-low seven-segment digits, with a page key
//   that scrolls across words wider than the display.
//
// Ports
//   CLOCK_50    in   system clock
//   reset_n     in   asynchronous active-low reset
//   step_key_n  in   raw step pushbutton, active-low, asynchronous
//   page_key_n  in   raw page pushbutton, active-low, asynchronous
//   run_mode    in   1 = free-run cpu_clock, 0 = single-step
//   chan_sel    in   displayed channel (values >= NUM_CHANNELS show channel 0)
//   chan_data   in   channel k at [k*DATA_WIDTH +: DATA_WIDTH]
//   cpu_clock   out  clock to the cpu
//   hex_n       out  digit i at [7*i +: 7], bit0 = seg a .. bit6 = seg g, active-low
//   page        out  current display page
//   step_count  out  accepted step presses, wraps at 16 bits
module hex_debug_console #(
   parameter int unsigned DATA_WIDTH      = 32,
   parameter int unsigned NUM_CHANNELS    = 2,
   parameter int unsigned NUM_DIGITS      = 4,
   parameter int unsigned DEBOUNCE_CYCLES = 500000,
   parameter int unsigned PULSE_CYCLES    = 4,
   parameter int unsigned RUN_DIV         = 25000000
) (
   input  logic                                  CLOCK_50,
   input  logic                                  reset_n,
   input  logic                                  step_key_n,
   input  logic                                  page_key_n,
   input  logic                                  run_mode,
   input  logic [((NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1)-1:0] chan_sel,
   input  logic [NUM_CHANNELS*DATA_WIDTH-1:0]    chan_data,
   output logic                                  cpu_clock,
   output logic [7*NUM_DIGITS-1:0]               hex_n,
   output logic [((((DATA_WIDTH + 4*NUM_DIGITS - 1) / (4*NUM_DIGITS)) > 1) ?
                  $clog2((DATA_WIDTH + 4*NUM_DIGITS - 1) / (4*NUM_DIGITS)) : 1)-1:0] page,
   output logic [15:0]                           step_count
);

   localparam int unsigned WIN_W     = 4 * NUM_DIGITS;
   localparam int unsigned NUM_PAGES = (DATA_WIDTH + WIN_W - 1) / WIN_W;
   localparam int unsigned PAD_W     = NUM_PAGES * WIN_W;
   localparam int unsigned PG_W      = (NUM_PAGES > 1) ? $clog2(NUM_PAGES) : 1;
   localparam int unsigned CNT_W     = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int unsigned PC_W      = $clog2(PULSE_CYCLES + 1);
   localparam int unsigned DIV_W     = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;

   localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [PC_W-1:0]  PULSE_LD  = PC_W'(PULSE_CYCLES);
   localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(RUN_DIV - 1);
   localparam logic [PG_W-1:0]  PG_LAST   = PG_W'(NUM_PAGES - 1);

   typedef enum logic {
      MODE_STEP = 1'b0,
      MODE_RUN  = 1'b1
   } mode_t;

   // ------------------------------------------------------------------
   // Key synchronisers and debouncers. Index 0 = step key, 1 = page key.
   // ------------------------------------------------------------------
   logic [1:0]       key_raw;
   logic [1:0]       key_s1;
   logic [1:0]       key_s2;
   logic [1:0]       key_acc;
   logic [1:0]       key_arm;
   logic [1:0]       key_stb;
   logic [CNT_W-1:0] key_cnt [2];

   assign key_raw = {page_key_n, step_key_n};

   // A key comes out of reset unarmed: it must be seen released for a full
   // debounce interval before presses are recognised, so a key held through
   // reset cannot produce a strobe until it is released and pressed again.
   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         key_s1  <= '1;
         key_s2  <= '1;
         key_acc <= '1;
         key_arm <= '0;
         key_stb <= '0;
         for (int unsigned k = 0; k < 2; k++) begin
            key_cnt[k] <= '0;
         end
      end else begin
         key_s1 <= key_raw;
         key_s2 <= key_s1;
         for (int unsigned k = 0; k < 2; k++) begin
            key_stb[k] <= 1'b0;
            if (!key_arm[k]) begin
               if (key_s2[k]) begin
                  if (key_cnt[k] == DB_LAST) begin
                     key_arm[k] <= 1'b1;
                     key_cnt[k] <= '0;
                  end else begin
                     key_cnt[k] <= key_cnt[k] + 1'b1;
                  end
               end else begin
                  key_cnt[k] <= '0;
               end
            end else if (key_s2[k] == key_acc[k]) begin
               key_cnt[k] <= '0;
            end else if (key_cnt[k] == DB_LAST) begin
               key_acc[k] <= key_s2[k];
               key_cnt[k] <= '0;
               key_stb[k] <= ~key_s2[k];
            end else begin
               key_cnt[k] <= key_cnt[k] + 1'b1;
            end
         end
      end
   end

   logic step_stb;
   logic page_stb;

   assign step_stb = key_stb[0];
   assign page_stb = key_stb[1];

   // ------------------------------------------------------------------
   // Mode synchroniser and CPU clock generator.
   // ------------------------------------------------------------------
   logic mode_s1;
   logic mode_s2;

   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         mode_s1 <= 1'b0;
         mode_s2 <= 1'b0;
      end else begin
         mode_s1 <= run_mode;
         mode_s2 <= mode_s1;
      end
   end

   mode_t            mode_q;
   mode_t            mode_d;
   mode_t            mode_req;
   logic             clk_d;
   logic [PC_W-1:0]  pulse_cnt;
   logic [PC_W-1:0]  pulse_d;
   logic [DIV_W-1:0] div_cnt;
   logic [DIV_W-1:0] div_d;
   logic [15:0]      steps_d;

   assign mode_req = mode_s2 ? MODE_RUN : MODE_STEP;

   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         mode_q     <= MODE_STEP;
         cpu_clock  <= 1'b0;
         pulse_cnt  <= '0;
         div_cnt    <= '0;
         step_count <= '0;
      end else begin
         mode_q     <= mode_d;
         cpu_clock  <= clk_d;
         pulse_cnt  <= pulse_d;
         div_cnt    <= div_d;
         step_count <= steps_d;
      end
   end

   // A mode change parks cpu_clock low with both counters cleared, so the
   // next rising edge in either mode always begins a full-length high phase.
   always_comb begin
      mode_d  = mode_q;
      clk_d   = cpu_clock;
      pulse_d = pulse_cnt;
      div_d   = div_cnt;
      steps_d = step_count;
      if (mode_req != mode_q) begin
         mode_d  = mode_req;
         clk_d   = 1'b0;
         pulse_d = '0;
         div_d   = '0;
      end else begin
         case (mode_q)
            MODE_STEP: begin
               if (pulse_cnt != '0) begin
                  pulse_d = pulse_cnt - 1'b1;
                  if (pulse_cnt == PC_W'(1)) begin
                     clk_d = 1'b0;
                  end
               end else if (step_stb) begin
                  clk_d   = 1'b1;
                  pulse_d = PULSE_LD;
                  steps_d = step_count + 16'd1;
               end
            end
            MODE_RUN: begin
               if (div_cnt == DIV_LAST) begin
                  div_d = '0;
                  clk_d = ~cpu_clock;
               end else begin
                  div_d = div_cnt + 1'b1;
               end
            end
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Page register.
   // ------------------------------------------------------------------
   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         page <= '0;
      end else if (page_stb) begin
         page <= (page == PG_LAST) ? '0 : page + 1'b1;
      end
   end

   // ------------------------------------------------------------------
   // Display path.
   // ------------------------------------------------------------------
   function automatic logic [6:0] seg7(input logic [3:0] nib);
      logic [6:0] s;
      case (nib)
         4'h0: s = 7'h40;
         4'h1: s = 7'h79;
         4'h2: s = 7'h24;
         4'h3: s = 7'h30;
         4'h4: s = 7'h19;
         4'h5: s = 7'h12;
         4'h6: s = 7'h02;
         4'h7: s = 7'h78;
         4'h8: s = 7'h00;
         4'h9: s = 7'h10;
         4'hA: s = 7'h08;
         4'hB: s = 7'h03;
         4'hC: s = 7'h46;
         4'hD: s = 7'h21;
         4'hE: s = 7'h06;
         default: s = 7'h0E;
      endcase
      return s;
   endfunction

   logic [DATA_WIDTH-1:0]   word;
   logic [PAD_W-1:0]        padded;
   logic [WIN_W-1:0]        win;
   logic [7*NUM_DIGITS-1:0] hex_d;

   // Out-of-range selects fall through to the channel 0 default.
   always_comb begin
      word = chan_data[DATA_WIDTH-1:0];
      for (int unsigned k = 1; k < NUM_CHANNELS; k++) begin
         if (32'(chan_sel) == k) begin
            word = chan_data[k*DATA_WIDTH +: DATA_WIDTH];
         end
      end
      padded                 = '0;
      padded[DATA_WIDTH-1:0] = word;
      win = padded[WIN_W-1:0];
      for (int unsigned p = 1; p < NUM_PAGES; p++) begin
         if (PG_W'(p) == page) begin
            win = padded[p*WIN_W +: WIN_W];
         end
      end
      hex_d = '1;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
         hex_d[7*i +: 7] = seg7(win[4*i +: 4]);
      end
   end

   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         hex_n <= '1;
      end else begin
         hex_n <= hex_d;
      end
   end

endmodule

// File: tb/tb_hex_debug_console.sv
module tb_hex_debug_console;

   logic        clk;
   logic        reset_n;
   logic        step_key_n;
   logic        page_key_n;
   logic        run_mode;
   logic [1:0]  chan_sel;
   logic [95:0] chan_data;
   logic        cpu_clock;
   logic [27:0] hex_n;
   logic [0:0]  page;
   logic [15:0] step_count;

   logic        sel20;
   logic [39:0] d20;
   logic        cpu_clock20;
   logic [27:0] hex20;
   logic [0:0]  page20;
   logic [15:0] step_count20;

   int total = 0;
   int bad   = 0;
   int exp_steps = 0;
   int pg = 0;

   logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   hex_debug_console #(
      .DATA_WIDTH(32), .NUM_CHANNELS(3), .NUM_DIGITS(4),
      .DEBOUNCE_CYCLES(8), .PULSE_CYCLES(4), .RUN_DIV(5)
   ) u_dut (
      .CLOCK_50(clk), .reset_n(reset_n), .step_key_n(step_key_n), .page_key_n(page_key_n),
      .run_mode(run_mode), .chan_sel(chan_sel), .chan_data(chan_data),
      .cpu_clock(cpu_clock), .hex_n(hex_n), .page(page), .step_count(step_count)
   );

   hex_debug_console #(
      .DATA_WIDTH(20), .NUM_CHANNELS(2), .NUM_DIGITS(4),
      .DEBOUNCE_CYCLES(8), .PULSE_CYCLES(4), .RUN_DIV(5)
   ) u_dut20 (
      .CLOCK_50(clk), .reset_n(reset_n), .step_key_n(step_key_n), .page_key_n(page_key_n),
      .run_mode(run_mode), .chan_sel(sel20), .chan_data(d20),
      .cpu_clock(cpu_clock20), .hex_n(hex20), .page(page20), .step_count(step_count20)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [95:0] data;
      logic [1:0]  sel;
      logic [27:0] exp;
   } vec_t;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // which: 0 = step key, 1 = page key, 2 = both together
   task automatic press(input int which, input int hold, input int after);
      if (which != 1) step_key_n = 1'b0;
      if (which != 0) page_key_n = 1'b0;
      ticks(hold);
      step_key_n = 1'b1;
      page_key_n = 1'b1;
      ticks(after);
   endtask

   task automatic wait_clk(input logic lvl, input int limit, output bit ok);
      int n;
      n = 0;
      while (cpu_clock !== lvl && n < limit) begin
         tick();
         n++;
      end
      ok = (cpu_clock === lvl);
   endtask

   task automatic sync_rise(input string name);
      bit ok;
      wait_clk(1'b0, 30, ok);
      if (ok) wait_clk(1'b1, 30, ok);
      check(name, 64'(ok), 64'd1);
   endtask

   task automatic phase_len(input logic lvl, output int len);
      len = 0;
      while (cpu_clock === lvl && len < 50) begin
         len++;
         tick();
      end
   endtask

   // Display reference: select the word, shift down by page and digit, look up the glyph.
   function automatic logic [27:0] model_hex(input logic [95:0] data, input int unsigned sel,
                                             input int unsigned pgn, input int unsigned dw,
                                             input int unsigned nch);
      int unsigned     ch;
      logic [95:0]     sh;
      longint unsigned w;
      logic [27:0]     r;
      ch = (sel < nch) ? sel : 0;
      sh = data >> (ch * dw);
      w  = sh[63:0] & ((64'd1 << dw) - 64'd1);
      for (int i = 0; i < 4; i++) begin
         r[7*i +: 7] = seg_tab[(w >> (pgn * 16 + 4 * i)) & 64'hF];
      end
      return r;
   endfunction

   initial begin
      vec_t vecs [6];
      int   first, last, highs, len, n;
      bit   ok;

      vecs[0] = '{{32'hDEADBEEF, 32'h00000090, 32'h0040001C}, 2'd0, {7'h40, 7'h40, 7'h79, 7'h46}};
      vecs[1] = '{{32'hDEADBEEF, 32'h00000090, 32'h0040001C}, 2'd1, {7'h40, 7'h40, 7'h10, 7'h40}};
      vecs[2] = '{{32'hDEADBEEF, 32'h00000090, 32'h0040001C}, 2'd2, {7'h03, 7'h06, 7'h06, 7'h0E}};
      vecs[3] = '{{32'hDEADBEEF, 32'h00000090, 32'h0040001C}, 2'd3, {7'h40, 7'h40, 7'h79, 7'h46}};
      vecs[4] = '{{32'h00000000, 32'h0000ABCD, 32'h00001234}, 2'd0, {7'h79, 7'h24, 7'h30, 7'h19}};
      vecs[5] = '{{32'h00000000, 32'h0000ABCD, 32'h00001234}, 2'd1, {7'h08, 7'h03, 7'h46, 7'h21}};

      reset_n    = 1'b0;
      step_key_n = 1'b1;
      page_key_n = 1'b1;
      run_mode   = 1'b0;
      chan_sel   = '0;
      chan_data  = '0;
      sel20      = 1'b0;
      d20        = {20'h00000, 20'hABCDE};
      ticks(2);
      check("reset_cpu_clock", 64'(cpu_clock), 64'd0);
      check("reset_hex", 64'(hex_n), 64'hFFFFFFF);
      check("reset_page", 64'(page), 64'd0);
      check("reset_steps", 64'(step_count), 64'd0);
      reset_n = 1'b1;
      ticks(20);

      // Display table at page 0
      for (int v = 0; v < 6; v++) begin
         chan_data = vecs[v].data;
         chan_sel  = vecs[v].sel;
         tick();
         check($sformatf("vec%0d_hex", v), 64'(hex_n), 64'(vecs[v].exp));
      end
      check("dw20_page0", 64'(hex20), 64'({7'h03, 7'h46, 7'h21, 7'h06}));

      // Step press with bounces
      step_key_n = 1'b0; ticks(3); step_key_n = 1'b1; ticks(3);
      step_key_n = 1'b0; ticks(3); step_key_n = 1'b1; ticks(3);
      step_key_n = 1'b0;
      first = -1; last = -1; highs = 0;
      for (int k = 1; k <= 60; k++) begin
         tick();
         if (cpu_clock === 1'b1) begin
            highs++;
            if (first < 0) first = k;
            last = k;
         end
         if (k == 30) step_key_n = 1'b1;
      end
      exp_steps++;
      check("step_first_high", 64'(first), 64'd11);
      check("step_high_cycles", 64'(highs), 64'd4);
      check("step_contiguous", 64'(last - first + 1), 64'd4);
      check("step_count_1", 64'(step_count), 64'(exp_steps));

      // Paging
      chan_data = {32'hDEADBEEF, 32'h00000090, 32'h0040001C};
      chan_sel  = 2'd0;
      press(1, 14, 14);
      pg = 1;
      check("page_1", 64'(page), 64'd1);
      check("page1_hex", 64'(hex_n), 64'({7'h40, 7'h40, 7'h19, 7'h40}));
      check("dw20_page1", 64'(hex20), 64'({7'h40, 7'h40, 7'h40, 7'h08}));
      press(1, 14, 14);
      pg = 0;
      check("page_wrap", 64'(page), 64'd0);
      check("page0_hex", 64'(hex_n), 64'({7'h40, 7'h40, 7'h79, 7'h46}));
      check("steps_after_page", 64'(step_count), 64'(exp_steps));

      // Simultaneous step and page
      press(2, 14, 14);
      exp_steps++;
      pg = 1;
      check("both_steps", 64'(step_count), 64'(exp_steps));
      check("both_page", 64'(page), 64'd1);
      press(1, 14, 14);
      pg = 0;

      // Run mode
      run_mode = 1'b1;
      sync_rise("run_rise_a");
      phase_len(1'b1, len); check("run_high_a", 64'(len), 64'd5);
      phase_len(1'b0, len); check("run_low_a", 64'(len), 64'd5);
      press(0, 14, 14);
      check("run_steps_ignored", 64'(step_count), 64'(exp_steps));
      sync_rise("run_rise_b");
      phase_len(1'b1, len); check("run_high_b", 64'(len), 64'd5);
      phase_len(1'b0, len); check("run_low_b", 64'(len), 64'd5);
      sync_rise("run_rise_c");
      tick();
      run_mode = 1'b0;
      n = 0;
      while (cpu_clock === 1'b1 && n < 10) begin
         tick();
         n++;
      end
      check("run_off_within_3", 64'(n <= 3), 64'd1);
      highs = 0;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (cpu_clock === 1'b1) highs++;
      end
      check("step_idle_low", 64'(highs), 64'd0);
      run_mode = 1'b1;
      sync_rise("run_rise_d");
      phase_len(1'b1, len); check("run_first_full_high", 64'(len), 64'd5);
      run_mode = 1'b0;
      ticks(10);

      // Randomised step presses
      for (int k = 0; k < 4; k++) begin
         press(0, $urandom_range(12, 20), $urandom_range(14, 20));
         exp_steps++;
         check($sformatf("rand_steps_%0d", k), 64'(step_count), 64'(exp_steps));
      end

      // Randomised display and paging
      for (int r = 0; r < 4; r++) begin
         n = $urandom_range(0, 2);
         for (int j = 0; j < n; j++) press(1, 14, 14);
         pg = (pg + n) % 2;
         check($sformatf("rand_page_%0d", r), 64'(page), 64'(pg));
         check($sformatf("rand_page20_%0d", r), 64'(page20), 64'(pg));
         for (int j = 0; j < 40; j++) begin
            chan_data = {$urandom, $urandom, $urandom};
            chan_sel  = 2'($urandom_range(0, 3));
            d20       = {8'($urandom), $urandom};
            sel20     = 1'($urandom_range(0, 1));
            tick();
            check("rand_hex", 64'(hex_n),
                  64'(model_hex(chan_data, int'(chan_sel), pg, 32, 3)));
            check("rand_hex20", 64'(hex20),
                  64'(model_hex({56'h0, d20}, int'(sel20), pg, 20, 2)));
         end
      end
      check("dw20_steps", 64'(step_count20), 64'(exp_steps));
      check("dw20_clock_idle", 64'(cpu_clock20), 64'd0);

      // Reset during a pulse with the key held through reset
      step_key_n = 1'b0;
      wait_clk(1'b1, 30, ok);
      check("pulse_before_reset", 64'(ok), 64'd1);
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      exp_steps = 0;
      pg = 0;
      check("rst_cpu_clock", 64'(cpu_clock), 64'd0);
      check("rst_hex", 64'(hex_n), 64'hFFFFFFF);
      check("rst_steps", 64'(step_count), 64'd0);
      check("rst_page", 64'(page), 64'd0);
      ticks(2);
      reset_n = 1'b1;
      tick();
      check("post_rst_hex", 64'(hex_n), 64'(model_hex(chan_data, int'(chan_sel), 0, 32, 3)));
      highs = 0;
      for (int k = 0; k < 40; k++) begin
         tick();
         if (cpu_clock === 1'b1) highs++;
      end
      check("held_key_no_pulse", 64'(highs), 64'd0);
      check("held_key_no_count", 64'(step_count), 64'd0);
      step_key_n = 1'b1;
      ticks(20);
      press(0, 14, 14);
      exp_steps++;
      check("repress_count", 64'(step_count), 64'(exp_steps));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/hex_debug_console.md
Name: hex_debug_console

Overview:
- Parametrised successor to the board-level CPU debug front end.
- Generates the CPU clock from a debounced step key or a divided free-run clock.
- Drives NUM_DIGITS active-low seven-segment digits with a hex view of one of NUM_CHANNELS debug words (e.g. pc, t0).
- A page key scrolls the view across words wider than the display.
- Sits between the board pins (CLOCK_50, KEY, SW, HEX) and the cpu instance.

Parameters:
- DATA_WIDTH, 32: width of each debug channel word.
- NUM_CHANNELS, 2: number of debug words on chan_data.
- NUM_DIGITS, 4: number of seven-segment digits driven.
- DEBOUNCE_CYCLES, 500000: stable cycles required to accept a key level change (10 ms at 50 MHz).
- PULSE_CYCLES, 4: high time of cpu_clock per accepted step press.
- RUN_DIV, 25000000: half-period of cpu_clock in run mode, in CLOCK_50 cycles.

Ports:
- CLOCK_50, input, 1: single system clock.
- reset_n, input, 1: asynchronous active-low reset.
- step_key_n, input, 1: raw step pushbutton, active-low, asynchronous to CLOCK_50.
- page_key_n, input, 1: raw page pushbutton, active-low, asynchronous.
- run_mode, input, 1: switch; 1 = free-run clock, 0 = single-step.
- chan_sel, input, $clog2(NUM_CHANNELS) (min 1): selects the displayed channel.
- chan_data, input, NUM_CHANNELS*DATA_WIDTH: channel k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- cpu_clock, output, 1: clock to the cpu.
- hex_n, output, 7*NUM_DIGITS: digit i occupies bits [7*i +: 7]; bit0 = seg a … bit6 = seg g; active-low.
- page, output, $clog2(NUM_PAGES) (min 1): current page, for LEDs.
- step_count, output, 16: number of accepted step presses, wraps at 0xFFFF -> 0.

Behaviour:
- Reset (async assert, sync release): cpu_clock = 0; page = 0; step_count = 0; hex_n all 7'h7F (blank) until the first post-reset cycle updates it; debounced key states = released; all counters = 0.
- Synchronisers: each raw key passes through a 2-flop synchroniser before debounce.
- Debounce:
  - Per-key counter; resets whenever the synchronised level equals the accepted level.
  - When the level differs for DEBOUNCE_CYCLES consecutive cycles, the accepted level flips.
  - A press event is a single-cycle strobe on an accepted 1 -> 0 transition. Releases generate no event.
  - Press-to-strobe latency: 2 + DEBOUNCE_CYCLES cycles.
- Step mode (run_mode = 0):
  - A step strobe while pulse_cnt == 0 sets cpu_clock = 1 on the next cycle and loads pulse_cnt.
  - cpu_clock stays high exactly PULSE_CYCLES cycles, then goes 0.
  - A strobe during an active pulse is ignored and is not counted.
  - Each accepted press increments step_count.
- Run mode (run_mode = 1):
  - cpu_clock toggles every RUN_DIV cycles; step strobes are ignored and not counted.
- Mode change:
  - run_mode is synchronised with 2 flops.
  - On the change, cpu_clock is forced to 0 and the divider/pulse counters are cleared, so no runt pulse shorter than PULSE_CYCLES (step) or RUN_DIV (run) is emitted. The 0 -> 1 edge of cpu_clock always starts a full high phase.
- Paging:
  - NUM_PAGES = ceil(DATA_WIDTH / (4*NUM_DIGITS)).
  - A page strobe sets page = page + 1, wrapping from NUM_PAGES-1 to 0.
  - With NUM_PAGES = 1, page stays 0.
  - Step and page strobes in the same cycle are both honoured independently.
- Display:
  - Digit i shows nibble chan_data[chan_sel][page*4*NUM_DIGITS + 4*i +: 4].
  - Bits at or beyond DATA_WIDTH read as 0.
  - A chan_sel value >= NUM_CHANNELS shows channel 0.
  - hex_n is registered: 1-cycle latency from any change of chan_data, chan_sel or page.
- Active-low hex encoding, 0–F: 40 79 24 30 19 12 02 78 00 10 08 03 46 21 06 0E (hex, 7-bit).
- Reset mid-debounce or mid-pulse: everything returns immediately to reset values. A held key must be re-debounced as released and re-pressed before it generates a strobe.

Test Plan:
- DEBOUNCE_CYCLES=8, PULSE_CYCLES=4. Press step_key_n with 3-cycle bounces, then hold 20 cycles -> exactly one 4-cycle cpu_clock pulse; step_count = 1; first high cycle at 11 cycles after stable low.
- chan_data = {32'h0000_0090, 32'h0040_001C}, chan_sel = 0, NUM_DIGITS=4 -> hex_n digits 0..3 = 46, 79, 40, 40 (C, 1, 0, 0). Set chan_sel = 1 -> next cycle digits = 40, 10, 40, 40 (0, 9, 0, 0).
- Same data, chan_sel = 0, one page press -> page = 1; digits show 0040 (40, 19, 40, 40). Second press -> page wraps to 0.
- run_mode = 1, RUN_DIV=5 -> cpu_clock period 10 cycles. Step presses change neither cpu_clock nor step_count. Switch to 0 mid-high-phase -> cpu_clock 0 within 3 cycles, no short pulse.
- DATA_WIDTH=20, NUM_DIGITS=4, data 20'hABCDE -> page 0 shows BCDE; page 1 shows 000A (digits 08, 40, 40, 40); NUM_PAGES = 2.
- Assert reset_n low during a pulse and during a held key -> cpu_clock = 0, hex_n = all 7F, step_count = 0. The held key yields no strobe until it is released and pressed again.
